mem_ctrl: RTL and testbench

Single-port RAM controller and arbiter between the instruction-fetch (IF) stage and the MEM stage of the pipeline. It serialises 1/2/4-byte requests onto a byte-wide, 1-cycle-latency RAM port and assembles or disassembles little-endian words. It raises per-requester stall requests that the stall controller folds into the `stall[4:0]` vector driving the IF/ID, ID/EX, EX/MEM and MEM/WB registers. MEM has priority because it always holds the older instruction.

---
 rtl/mem_ctrl_pkg.sv | 38 +++
 rtl/mem_ctrl_ibuf.sv | 51 +++++
 rtl/mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, memory-length codes, FSM encoding and the
// latched-transfer record used by mem_ctrl and its instruction buffer.
package mem_ctrl_pkg;

    localparam int AddrLen = 32;
    localparam int RegLen  = 32;
    localparam logic [RegLen-1:0] ZeroWord = '0;

    // mem_len encodings; 2'b11 is reserved and handled as a word
    localparam logic [1:0] MemByte = 2'b00;
    localparam logic [1:0] MemHalf = 2'b01;
    localparam logic [1:0] MemWord = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Transfer captured at acceptance so requesters may change inputs freely
    typedef struct packed {
        logic [AddrLen-1:0] base;
        logic [RegLen-1:0]  wdata;
        logic [2:0]         n;      // byte count 1/2/4
    } xfer_t;

    // Byte count for a MEM-stage access length code
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            MemByte: return 3'd1;
            MemHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ibuf.sv
// mem_ctrl_ibuf: one-entry instruction buffer {valid, fetch address, word}.
// Compiled and instantiated only when MEMCTRL_IBUF_EN is defined.
`ifdef MEMCTRL_IBUF_EN
module mem_ctrl_ibuf
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [AddrLen-1:0] lookup_addr,
    output logic               hit,
    output logic [RegLen-1:0]  hit_data,
    input  logic               fill,
    input  logic [AddrLen-1:0] fill_addr,
    input  logic [RegLen-1:0]  fill_data,
    input  logic               inv,
    input  logic [AddrLen-1:0] inv_addr,
    input  logic [2:0]         inv_n
);
    logic               vld;
    logic [AddrLen-1:0] tag;
    logic [RegLen-1:0]  word;
    logic [AddrLen-1:0] d_st;
    logic [AddrLen-1:0] d_bf;
    logic               overlap;

    assign hit      = vld && (lookup_addr == tag);
    assign hit_data = word;

    // Two short ranges on the 2^32 circle overlap iff either start lies
    // inside the other range; modular subtraction handles the wrap.
    assign d_st    = inv_addr - tag;
    assign d_bf    = tag - inv_addr;
    assign overlap = (d_st < 32'd4) || (d_bf < AddrLen'(inv_n));

    // Fill on every completed RAM fetch; drop the entry on a clobbering store
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld  <= 1'b0;
            tag  <= '0;
            word <= '0;
        end else if (fill) begin
            vld  <= 1'b1;
            tag  <= fill_addr;
            word <= fill_data;
        end else if (inv && overlap) begin
            vld  <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF and MEM 1/2/4-byte requests onto a byte-wide RAM
// with 1-cycle read latency; MEM wins arbitration (older instruction).
// Optional one-entry instruction buffer: define MEMCTRL_IBUF_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [AddrLen-1:0] if_addr,
    output logic [RegLen-1:0]  if_data,
    output logic               if_done,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [1:0]         mem_len,
    input  logic [AddrLen-1:0] mem_addr,
    input  logic [RegLen-1:0]  mem_wdata,
    output logic [RegLen-1:0]  mem_rdata,
    output logic               mem_done,
    output logic [AddrLen-1:0] ram_addr,
    output logic               ram_we,
    output logic [7:0]         ram_dout,
    input  logic [7:0]         ram_din,
    output logic               stall_req_if,
    output logic               stall_req_mem
);
    state_t          state;
    xfer_t           xfer;
    logic [2:0]      k;          // byte index; k == n is the trailing capture cycle on reads
    logic [2:0]      k_nxt;
    logic [2:0]      mem_n;
    logic [1:0]      cap_lane;
    logic            last_cap;
    logic [3:0][7:0] lanes;
    logic [3:0][7:0] rd_word;
    logic [3:0][7:0] wr_bytes;
    logic            ibuf_hit;
    logic [RegLen-1:0] ibuf_data;

    assign k_nxt    = k + 3'd1;
    assign mem_n    = len_bytes(mem_len);
    assign cap_lane = 2'(k - 3'd1);
    assign last_cap = (k == xfer.n);
    assign wr_bytes = xfer.wdata;

    assign stall_req_if  = if_req  & ~if_done;
    assign stall_req_mem = mem_req & ~mem_done;

    // Assembled read word including the byte arriving this cycle
    always_comb begin
        rd_word           = lanes;
        rd_word[cap_lane] = ram_din;
    end

`ifdef MEMCTRL_IBUF_EN
    logic ibuf_fill;
    logic ibuf_inv;

    assign ibuf_fill = (state == IF_RD) && last_cap;
    assign ibuf_inv  = (state == IDLE) && mem_req && mem_we;

    mem_ctrl_ibuf u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (if_addr),
        .hit         (ibuf_hit),
        .hit_data    (ibuf_data),
        .fill        (ibuf_fill),
        .fill_addr   (xfer.base),
        .fill_data   (rd_word),
        .inv         (ibuf_inv),
        .inv_addr    (mem_addr),
        .inv_n       (mem_n)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = ZeroWord;
`endif

    // Arbitration FSM with registered RAM port and completion outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            xfer      <= '0;
            k         <= '0;
            lanes     <= '0;
            if_data   <= '0;
            if_done   <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    k     <= '0;
                    lanes <= '0;
                    if (mem_req) begin
                        xfer     <= '{base: mem_addr, wdata: mem_wdata, n: mem_n};
                        ram_addr <= mem_addr;
                        if (mem_we) begin
                            state    <= MEM_WR;
                            ram_we   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end else begin
                            state    <= MEM_RD;
                        end
                    end else if (if_req && ibuf_hit) begin
                        state   <= DONE;
                        if_done <= 1'b1;
                        if_data <= ibuf_data;
                    end else if (if_req) begin
                        xfer     <= '{base: if_addr, wdata: ZeroWord, n: 3'd4};
                        ram_addr <= if_addr;
                        state    <= IF_RD;
                    end
                end

                IF_RD, MEM_RD: begin
                    // ram_din carries the byte addressed in the previous cycle
                    if (k != 3'd0)
                        lanes[cap_lane] <= ram_din;
                    if (last_cap) begin
                        state <= DONE;
                        if (state == IF_RD) begin
                            if_done <= 1'b1;
                            if_data <= rd_word;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= rd_word;
                        end
                    end else begin
                        k        <= k_nxt;
                        ram_addr <= (k_nxt < xfer.n) ? xfer.base + AddrLen'(k_nxt) : '0;
                    end
                end

                MEM_WR: begin
                    if (k == xfer.n - 3'd1) begin
                        state    <= DONE;
                        mem_done <= 1'b1;
                        ram_addr <= '0;
                        ram_we   <= 1'b0;
                        ram_dout <= '0;
                    end else begin
                        k        <= k_nxt;
                        ram_addr <= xfer.base + AddrLen'(k_nxt);
                        ram_dout <= wr_bytes[k_nxt[1:0]];
                    end
                end

                DONE: begin
                    // Single-cycle pulse; held requests are not re-sampled here
                    state     <= IDLE;
                    if_done   <= 1'b0;
                    mem_done  <= 1'b0;
                    if_data   <= '0;
                    mem_rdata <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl. A byte-addressed
// reference memory predicts load/fetch data, completion cycles and the exact
// RAM port traffic; a monitor pops expectations when *_done pulses.
module tb_mem_ctrl;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  dout;
    } act_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = '0;
    logic        stall_req_if;
    logic        stall_req_mem;

    mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_data       (if_data),
        .if_done       (if_done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_len       (mem_len),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_done      (mem_done),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din),
        .stall_req_if  (stall_req_if),
        .stall_req_mem (stall_req_mem)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] ram [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];
    exp_t if_q[$];
    exp_t mem_q[$];
    act_t act_q[$];
    bit          tb_buf_vld = 1'b0;
    logic [31:0] tb_buf_addr = '0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic bit overlaps(input logic [31:0] a, input int n, input logic [31:0] b);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++)
                if (a + 32'(i) == b + 32'(j)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pick_maddr();
        logic [31:0] bases [5];
        bases = '{32'h0000_0100, 32'h0000_2000, 32'h0000_8000, 32'hFFFF_FFFC, 32'h0000_0104};
        return bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 5));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-wide RAM, one-cycle read latency
    always @(posedge clk) begin
        ram_din <= ram_rd(ram_addr);
        if (ram_we) ram[ram_addr] = ram_dout;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: completion pulses against the scoreboard, and RAM port activity log
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (if_done) begin
                if (if_q.size() == 0) chk("if_done_unexpected", 64'(if_done), 64'd0);
                else begin
                    e = if_q.pop_front();
                    chk("if_data", 64'(if_data), 64'(e.data));
                    chk("if_done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (mem_done) begin
                if (mem_q.size() == 0) chk("mem_done_unexpected", 64'(mem_done), 64'd0);
                else begin
                    e = mem_q.pop_front();
                    if (e.chk_data) chk("mem_rdata", 64'(mem_rdata), 64'(e.data));
                    chk("mem_done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (ram_we || ram_addr != 32'd0)
                act_q.push_back('{addr: ram_addr, we: ram_we, dout: ram_dout});
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_data"},   64'(if_data),   64'd0);
        chk({tag, "_if_done"},   64'(if_done),   64'd0);
        chk({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
        chk({tag, "_mem_done"},  64'(mem_done),  64'd0);
        chk({tag, "_ram_addr"},  64'(ram_addr),  64'd0);
        chk({tag, "_ram_we"},    64'(ram_we),    64'd0);
        chk({tag, "_ram_dout"},  64'(ram_dout),  64'd0);
    endtask

    // Issue one transaction (IF, MEM or both at once) and check its RAM traffic
    task automatic run_txn(input bit do_if, input logic [31:0] iaddr, input bit do_mem,
                           input bit we, input logic [1:0] len,
                           input logic [31:0] maddr, input logic [31:0] wdata);
        act_t        exp_a[$];
        logic [31:0] d;
        logic [31:0] a;
        int          n, lm, lf, c0;
        bit          hit, stall_bad, timed_out;
        c0 = cyc;
        lm = 0;
        stall_bad = 1'b0;
        if (do_mem) begin
            n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
            d = '0;
            for (int i = 0; i < n; i++) begin
                a = maddr + 32'(i);
                if (we) begin
                    ref_mem[a] = wdata[8*i +: 8];
                    exp_a.push_back('{addr: a, we: 1'b1, dout: wdata[8*i +: 8]});
                end else begin
                    d[8*i +: 8] = ref_rd(a);
                    if (a != 32'd0) exp_a.push_back('{addr: a, we: 1'b0, dout: 8'd0});
                end
            end
`ifdef MEMCTRL_IBUF_EN
            if (we && overlaps(maddr, n, tb_buf_addr)) tb_buf_vld = 1'b0;
`endif
            lm = we ? n + 1 : n + 2;
            mem_q.push_back('{data: d, cyc: c0 + lm, chk_data: !we});
        end
        if (do_if) begin
            hit = 1'b0;
`ifdef MEMCTRL_IBUF_EN
            hit = tb_buf_vld && (tb_buf_addr == iaddr);
`endif
            d = '0;
            for (int i = 0; i < 4; i++) begin
                a = iaddr + 32'(i);
                d[8*i +: 8] = ref_rd(a);
                if (!hit && a != 32'd0) exp_a.push_back('{addr: a, we: 1'b0, dout: 8'd0});
            end
            if (!hit) begin
                tb_buf_vld  = 1'b1;
                tb_buf_addr = iaddr;
            end
            lf = hit ? 1 : 6;
            if_q.push_back('{data: d, cyc: c0 + (do_mem ? lm + 1 : 0) + lf, chk_data: 1'b1});
        end
        if_addr   = iaddr;
        mem_we    = we;
        mem_len   = len;
        mem_addr  = maddr;
        mem_wdata = wdata;
        if_req    = do_if;
        mem_req   = do_mem;
        for (int i = 0; i < 40 && (if_req || mem_req); i++) begin
            @(negedge clk);
            if (if_req  && (stall_req_if  !== ~if_done))  stall_bad = 1'b1;
            if (mem_req && (stall_req_mem !== ~mem_done)) stall_bad = 1'b1;
            if (if_done)  if_req  = 1'b0;
            if (mem_done) mem_req = 1'b0;
        end
        timed_out = if_req || mem_req;
        chk("txn_timeout", 64'(timed_out), 64'd0);
        if (timed_out) begin
            if_req = 1'b0; mem_req = 1'b0;
            rst = 1'b0; @(negedge clk); rst = 1'b1;
            if_q.delete(); mem_q.delete(); tb_buf_vld = 1'b0;
        end
        chk("stall_req", 64'(stall_bad), 64'd0);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        chk("ram_act_count", 64'(act_q.size()), 64'(exp_a.size()));
        for (int i = 0; i < act_q.size() && i < exp_a.size(); i++)
            chk("ram_act", 64'(act_q[i]), 64'(exp_a[i]));
        chk("scoreboard_drained", 64'(if_q.size() + mem_q.size()), 64'd0);
        act_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05;
        ref_mem[32'h102] = 8'h10; ref_mem[32'h103] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_stall_if",  64'(stall_req_if),  64'd0);
        chk("reset_stall_mem", 64'(stall_req_mem), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Word fetch, byte store, contention, wrap-around load
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
        run_txn(0, 32'h0, 1, 1, 2'b00, 32'h2003, 32'hAABBCCDD);
        run_txn(1, 32'h104, 1, 0, 2'b01, 32'h8000, 32'h0);
        run_txn(0, 32'h0, 1, 0, 2'b10, 32'hFFFF_FFFE, 32'h0);

        // Buffer refetch, clobbering store, refetch
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
        run_txn(0, 32'h0, 1, 1, 2'b00, 32'h102, 32'h0000_0077);
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);

        // Reset during the third byte of a fetch
        if_addr = 32'h100;
        if_req  = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_addr", 64'(ram_addr), 64'h102);
        rst    = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b1;
        tb_buf_vld = 1'b0;
        repeat (8) @(negedge clk);
        act_q.delete();
        run_txn(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);

        // Randomized mix
        for (int t = 0; t < 80; t++) begin
            int pick;
            pick = $urandom_range(0, 2);
            run_txn(pick != 1, 32'h100 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 1)),
                    pick != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    pick_maddr(), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
